// File: rtl/prog_rom_pkg.sv
// Shared definitions for the multi-bank demo program ROM: opcodes, FSM states, contents.
// No logic of its own; rom_byte() is a pure lookup used by the array sub-module.
// Backpressure: not applicable.
package prog_rom_pkg;

    localparam logic [7:0] NOP     = 8'h00;
    localparam logic [7:0] LDA_IMM = 8'h01;
    localparam logic [7:0] STA_IMM = 8'h03;
    localparam logic [7:0] ADD_IMM = 8'h05;
    localparam logic [7:0] LSL_IMM = 8'h0F;
    localparam logic [7:0] JMP_IMM = 8'h1B;
    localparam logic [7:0] BNE_IMM = 8'h1D;
    localparam logic [7:0] BPL_IMM = 8'h21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bank 0 counts then shifts a bit; bank 1 walks a single bit. Everything else is NOP.
    function automatic logic [7:0] rom_byte(input int bank, input int addr);
        logic [7:0] b;
        b = NOP;
        if (bank == 0) begin
            case (addr)
                'h01: b = LDA_IMM;
                'h02: b = 8'h00;
                'h04: b = ADD_IMM;
                'h05: b = 8'h01;
                'h06: b = STA_IMM;
                'h07: b = 8'h40;
                'h08: b = BNE_IMM;
                'h09: b = 8'h03;
                'h0A: b = LDA_IMM;
                'h0B: b = 8'h01;
                'h0C: b = STA_IMM;
                'h0D: b = 8'h40;
                'h0F: b = LSL_IMM;
                'h10: b = 8'h01;
                'h11: b = STA_IMM;
                'h12: b = 8'h40;
                'h13: b = BPL_IMM;
                'h14: b = 8'h0E;
                'h15: b = JMP_IMM;
                default: b = NOP;
            endcase
        end else if (bank == 1) begin
            case (addr)
                'h01: b = LDA_IMM;
                'h02: b = 8'h80;
                'h03: b = STA_IMM;
                'h04: b = 8'h40;
                'h05: b = JMP_IMM;
                default: b = NOP;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/prog_rom_array.sv
// Combinational {bank, addr} -> byte lookup of the demo program contents.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module prog_rom_array
    import prog_rom_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int BANK_W = 2
) (
    input  logic [BANK_W-1:0] bank,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    always_comb begin
        data = rom_byte(int'(bank), int'(addr));
    end

endmodule

// File: rtl/prog_rom_bank.sv
// Multi-bank registered program ROM with request/valid handshake; optional PROG_ROM_PREFETCH_EN next-address buffer.
// Latency: 1+WAIT_CYCLES cycles from acceptance to rd_valid (1 cycle on a prefetch hit).
// Backpressure: busy high while a read is in flight; rd_req is ignored until busy drops.
module prog_rom_bank
    import prog_rom_pkg::*;
#(
    parameter  int ADDR_W      = 5,
    parameter  int DATA_W      = 8,
    parameter  int NUM_BANKS   = 4,
    parameter  int WAIT_CYCLES = 1,
    localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [BANK_W-1:0] bank_active
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [BANK_W-1:0] bank_q;
    logic              accept;
    logic              pf_hit;
    logic [ADDR_W-1:0] lk_addr;
    logic [BANK_W-1:0] lk_bank;
    logic [7:0]        lk_byte;
    logic [7:0]        resp_byte;

    assign accept      = rd_req && (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign rd_valid    = (state == ST_RESP);
    assign bank_active = bank_q;

    // In IDLE the zero-wait path must look up the request being accepted right now.
    assign lk_addr = (state == ST_IDLE) ? addr     : addr_q;
    assign lk_bank = (state == ST_IDLE) ? bank_sel : bank_q;

    prog_rom_array #(
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_array (
        .bank (lk_bank),
        .addr (lk_addr),
        .data (lk_byte)
    );

`ifdef PROG_ROM_PREFETCH_EN
    logic              pf_vld;
    logic              pf_pend;
    logic [3:0]        pf_cnt;
    logic [ADDR_W-1:0] pf_addr;
    logic [7:0]        pf_dat;
    logic [7:0]        pf_byte;

    prog_rom_array #(
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_pf_array (
        .bank (bank_q),
        .addr (pf_addr),
        .data (pf_byte)
    );

    assign pf_hit    = accept && pf_vld && (addr == pf_addr) && (bank_sel == bank_q);
    assign resp_byte = pf_hit ? pf_dat : lk_byte;

    // Background fetch of the next sequential address; any acceptance discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_vld  <= 1'b0;
            pf_pend <= 1'b0;
            pf_cnt  <= 4'd0;
            pf_addr <= '0;
            pf_dat  <= 8'h00;
        end else if (accept) begin
            pf_vld  <= 1'b0;
            pf_pend <= 1'b0;
        end else if (state == ST_RESP) begin
            pf_addr <= addr_q + ADDR_W'(1);
            pf_cnt  <= 4'(WAIT_CYCLES);
            pf_pend <= 1'b1;
            pf_vld  <= 1'b0;
        end else if (state == ST_IDLE && pf_pend) begin
            if (pf_cnt <= 4'd1) begin
                pf_vld  <= 1'b1;
                pf_dat  <= pf_byte;
                pf_pend <= 1'b0;
            end else begin
                pf_cnt <= pf_cnt - 4'd1;
            end
        end
    end
`else
    assign pf_hit    = 1'b0;
    assign resp_byte = lk_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (pf_hit || WAIT_CYCLES == 0) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            addr_q  <= '0;
            bank_q  <= '0;
            rd_data <= '0;
        end else begin
            if (accept) begin
                addr_q <= addr;
                bank_q <= bank_sel;
                cnt    <= CNT_LOAD;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nxt == ST_RESP) begin
                rd_data <= DATA_W'(resp_byte);
            end
        end
    end

endmodule

// File: tb/tb_prog_rom_bank.sv
// Self-checking bench for prog_rom_bank: vector table, hand-written corner sequences, random reads vs a model.
// Two instances: default parameters, and ADDR_W=6 with zero wait states.
module tb_prog_rom_bank;

    localparam int W = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] bank_sel, bank_sel2;
    logic       rd_req, rd_req2;
    logic [4:0] addr;
    logic [5:0] addr2;
    logic [7:0] rd_data, rd_data2;
    logic       rd_valid, rd_valid2, busy, busy2;
    logic [1:0] bank_active, bank_active2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_rom_bank #(.ADDR_W(5), .DATA_W(8), .NUM_BANKS(4), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .rd_req(rd_req), .addr(addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .bank_active(bank_active)
    );

    prog_rom_bank #(.ADDR_W(6), .DATA_W(8), .NUM_BANKS(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel2), .rd_req(rd_req2), .addr(addr2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .bank_active(bank_active2)
    );

    // Reference contents written out as plain program listings.
    logic [7:0] b0 [23] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h05, 8'h01, 8'h03, 8'h40,
                            8'h1D, 8'h03, 8'h01, 8'h01, 8'h03, 8'h40, 8'h00, 8'h0F,
                            8'h01, 8'h03, 8'h40, 8'h21, 8'h0E, 8'h1B, 8'h00};
    logic [7:0] b1 [7]  = '{8'h00, 8'h01, 8'h80, 8'h03, 8'h40, 8'h1B, 8'h00};

    function automatic logic [7:0] ref_byte(input int b, input int a);
        if (b == 0 && a < 23) return b0[a];
        if (b == 1 && a < 7)  return b1[a];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in the current cycle, then waits (bounded) for rd_valid.
    task automatic do_read(input bit which, input int b, input int a,
                           output logic [7:0] d, output int lat,
                           output logic [1:0] ba, output bit busy_ok);
        if (!which) begin
            bank_sel = 2'(b); addr = 5'(a); rd_req = 1'b1;
        end else begin
            bank_sel2 = 2'(b); addr2 = 6'(a); rd_req2 = 1'b1;
        end
        tick();
        rd_req    = 1'b0;
        rd_req2   = 1'b0;
        bank_sel  = 2'($urandom);
        addr      = 5'($urandom);
        bank_sel2 = 2'($urandom);
        addr2     = 6'($urandom);
        lat       = 1;
        busy_ok   = 1'b1;
        while ((which ? rd_valid2 : rd_valid) !== 1'b1 && lat < 40) begin
            if ((which ? busy2 : busy) !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if ((which ? busy2 : busy) !== 1'b1) busy_ok = 1'b0;
        d  = which ? rd_data2 : rd_data;
        ba = which ? bank_active2 : bank_active;
    endtask

    typedef struct {
        bit         which;
        int         bank;
        int         addr;
        logic [7:0] exp_d;
        int         exp_lat;
    } vec_t;

    initial begin
        vec_t       vecs[8];
        logic [7:0] d;
        logic [1:0] ba;
        int         lat;
        bit         bok;
        bit         saw_valid;
        bit         have_last;
        int         last_a, last_b, gap, a, b, exp_lat;

        vecs[0] = '{0, 0, 'h01, 8'h01, 2};
        vecs[1] = '{0, 1, 'h02, 8'h80, 2};
        vecs[2] = '{0, 3, 'h02, 8'h00, 2};
        vecs[3] = '{0, 0, 'h1F, 8'h00, 2};
        vecs[4] = '{0, 0, 'h13, 8'h21, 2};
        vecs[5] = '{1, 0, 'h0F, 8'h0F, 1};
        vecs[6] = '{1, 0, 'h25, 8'h00, 1};
        vecs[7] = '{1, 1, 'h05, 8'h1B, 1};

        rst_n = 1'b0; rd_req = 1'b0; rd_req2 = 1'b0;
        bank_sel = 2'd0; addr = 5'd0; bank_sel2 = 2'd0; addr2 = 6'd0;
        tick(); tick();
        chk("reset rd_data", 32'(rd_data), 32'h0);
        chk("reset rd_valid", 32'(rd_valid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset bank_active", 32'(bank_active), 32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_read(vecs[i].which, vecs[i].bank, vecs[i].addr, d, lat, ba, bok);
            chk($sformatf("vec%0d data", i), 32'(d), 32'(vecs[i].exp_d));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d bank_active", i), 32'(ba), 32'(vecs[i].bank));
            chk($sformatf("vec%0d busy", i), 32'(bok), 32'h1);
            tick();
            chk($sformatf("vec%0d idle after", i),
                32'({vecs[i].which ? rd_valid2 : rd_valid, vecs[i].which ? busy2 : busy}), 32'h0);
        end

        // Request held across a busy period while bank/addr change underneath it.
        bank_sel = 2'd0; addr = 5'h09; rd_req = 1'b1;
        tick();
        bank_sel = 2'd1; addr = 5'h02;
        chk("held busy c1", 32'(busy), 32'h1);
        tick();
        chk("held valid c2", 32'(rd_valid), 32'h1);
        chk("held data c2", 32'(rd_data), 32'h03);
        chk("held bank_active c2", 32'(bank_active), 32'h0);
        tick();
        chk("held busy c3", 32'(busy), 32'h0);
        tick();
        rd_req = 1'b0;
        chk("held accepted c4", 32'({busy, bank_active}), 32'h5);
        tick();
        chk("held valid c5", 32'(rd_valid), 32'h1);
        chk("held data c5", 32'(rd_data), 32'h80);
        tick();

        // Reset in the middle of a read aborts it.
        bank_sel = 2'd0; addr = 5'h04; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("abort outputs", 32'({rd_data, rd_valid, busy, bank_active}), 32'h0);
        saw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rd_valid !== 1'b0) saw_valid = 1'b1;
        end
        rst_n = 1'b1;
        tick();
        if (rd_valid !== 1'b0) saw_valid = 1'b1;
        chk("abort no valid", 32'(saw_valid), 32'h0);
        do_read(0, 0, 'h01, d, lat, ba, bok);
        chk("post-reset data", 32'(d), 32'h01);
        chk("post-reset latency", 32'(lat), 32'd2);
        chk("post-reset busy", 32'(bok), 32'h1);
        tick();

`ifdef PROG_ROM_PREFETCH_EN
        do_read(0, 0, 'h04, d, lat, ba, bok);
        tick(); tick(); tick();
        do_read(0, 0, 'h05, d, lat, ba, bok);
        chk("pf hit data", 32'(d), 32'h01);
        chk("pf hit latency", 32'(lat), 32'd1);
        tick();
        do_read(0, 0, 'h04, d, lat, ba, bok);
        tick(); tick(); tick();
        do_read(0, 0, 'h07, d, lat, ba, bok);
        chk("pf miss data", 32'(d), 32'h40);
        chk("pf miss latency", 32'(lat), 32'd2);
        tick();
        do_read(0, 0, 'h1F, d, lat, ba, bok);
        tick(); tick(); tick();
        do_read(0, 0, 'h00, d, lat, ba, bok);
        chk("pf wrap data", 32'(d), 32'h00);
        chk("pf wrap latency", 32'(lat), 32'd1);
        tick();
        last_a = 'h00;
`else
        last_a = 'h01;
`endif

        // Random reads; the model knows only the contents table and the latency rules.
        have_last = 1'b1;
        last_b    = 0;
        gap       = 0;
        for (int i = 0; i < 60; i++) begin
            if (have_last && $urandom_range(0, 2) == 0) begin
                a = (last_a + 1) % 32;
                b = last_b;
            end else begin
                a = int'($urandom_range(0, 31));
                b = int'($urandom_range(0, 3));
            end
            exp_lat = 1 + W;
`ifdef PROG_ROM_PREFETCH_EN
            if (have_last && a == (last_a + 1) % 32 && b == last_b && gap >= W) exp_lat = 1;
`endif
            do_read(0, b, a, d, lat, ba, bok);
            chk($sformatf("rand%0d data b%0d a%0h", i, b, a), 32'(d), 32'(ref_byte(b, a)));
            chk($sformatf("rand%0d latency", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("rand%0d bank_active", i), 32'(ba), 32'(b));
            have_last = 1'b1;
            last_a    = a;
            last_b    = b;
            gap       = int'($urandom_range(0, 3));
            for (int k = 0; k <= gap; k++) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_rom_bank.md
# prog_rom_bank

Multi-bank, registered program ROM for the minibyte CPU instruction/operand fetch path. It holds several selectable demo programs, each up to 2^ADDR_W bytes. Reads use a request/valid handshake with a configurable wait-state count, so the CPU fetch FSM sees a realistic memory latency. It replaces the single-program combinational demo ROM and sits between the CPU address bus and the instruction register.

## Interface
- ADDR_W, 5, address width; ROM depth per bank = 2^ADDR_W.
- DATA_W, 8, data width. Only 8 is populated; wider widths zero-extend the byte.
- NUM_BANKS, 4, number of selectable banks, ≥1.
- WAIT_CYCLES, 1, wait states per read, 0..15.

Ports, clock and reset first:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bank_sel  in  max(1,$clog2(NUM_BANKS))  bank for the next accepted request.
- rd_req  in  1  read request.
- addr  in  ADDR_W  byte address.
- rd_data  out  DATA_W  read data, held until the next response.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- busy  out  1  high while a read is in flight; requests are ignored.
- bank_active  out  width of bank_sel  bank of the last accepted request.

## Operation
- Acceptance: rd_req && !busy.
  - addr and bank_sel are captured into registers on that edge.
  - Later changes to addr or bank_sel do not affect the in-flight read.
  - rd_req while busy is ignored; the requester holds rd_req until accepted.
- FSM: IDLE → WAIT (WAIT_CYCLES cycles, down-counter) → RESP → IDLE.
  - With WAIT_CYCLES=0, IDLE → RESP directly.
  - busy = (state != IDLE).
- RESP: rd_valid=1 for that cycle; rd_data is loaded on entry to RESP.
- Contents, selected by the captured {bank, addr}:
  - Bank 0 (count/shift demo), hex: 00:00 01:01 02:00 03:00 04:05 05:01 06:03 07:40 08:1D 09:03 0A:01 0B:01 0C:03 0D:40 0E:00 0F:0F 10:01 11:03 12:40 13:21 14:0E 15:1B 16:00.
  - Bank 1 (walking-bit demo): 00:00 01:01 02:80 03:03 04:40 05:1B 06:00.
  - All other addresses, and banks ≥2: 0x00 (NOP).
  - Addresses ≥ 0x20 read 0x00 when ADDR_W > 5.
- Bank change takes effect only at the next acceptance. bank_active updates on the acceptance edge.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, bank_active=0, state=IDLE, counter=0, prefetch buffer invalid.
- Acceptance at cycle N:
  - busy=1 in cycles N+1 .. N+1+WAIT_CYCLES.
  - rd_valid=1 in cycle N+1+WAIT_CYCLES.
  - Next acceptance possible in cycle N+2+WAIT_CYCLES.
- Throughput: one read per 2+WAIT_CYCLES cycles.
- Reset asserted mid-read: the read is aborted immediately and no rd_valid is produced. After rd_n release the block is in IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. The prefetch address after the top address is 0.

## Configuration
- PROG_ROM_PREFETCH_EN defined:
  - After each RESP, the block fetches (last_addr+1) mod 2^ADDR_W from the same bank in the background while IDLE.
  - The prefetch buffer becomes valid after WAIT_CYCLES idle cycles.
  - Hit (buffer valid, addr matches, bank_sel == bank_active): IDLE → RESP, rd_valid in cycle N+1.
  - Miss, or a request arriving before the buffer is valid: the prefetch is discarded and the normal path is taken.
  - A bank_sel change at acceptance is always a miss.
- PROG_ROM_PREFETCH_EN undefined: no buffer logic; latency is always 1+WAIT_CYCLES.

## Structure
- Package prog_rom_pkg holds:
  - opcode constants (NOP=00, LDA_IMM=01, STA_IMM=03, ADD_IMM=05, LSL_IMM=0F, JMP_IMM=1B, BNE_IMM=1D, BPL_IMM=21);
  - the FSM state enum;
  - the contents function rom_byte(bank, addr).
- Sub-module prog_rom_array: combinational lookup of {bank, addr} → byte. The top level owns the FSM, counter, output registers and prefetch buffer.

## Test plan
Defaults unless stated: WAIT_CYCLES=1, NUM_BANKS=4.
1. Reset, bank_sel=0, rd_req with addr=0x01 at cycle 0 → busy=1 in cycles 1–2, rd_valid in cycle 2, rd_data=0x01.
2. Bank select: bank_sel=1, addr=0x02 → 0x80. bank_sel=3, addr=0x02 → 0x00. bank_active follows (1, then 3).
3. bank_sel=0, addr=0x09 accepted; bank_sel→1 and rd_req held high the next cycle → data 0x03, bank_active=0. The held request is accepted in cycle 3.
4. Boundaries:
   - addr=0x1F → 0x00.
   - ADDR_W=6, addr=0x25 → 0x00.
   - WAIT_CYCLES=0, addr=0x0F → rd_valid in cycle 1, data 0x0F.
5. rst_n low in cycle 1 of a read → no rd_valid; all outputs 0. First request after release behaves as in scenario 1.
6. PROG_ROM_PREFETCH_EN defined:
   - Read 0x04, wait 2 idle cycles, read 0x05 → rd_valid one cycle after acceptance, data 0x01.
   - Read 0x07 instead → latency 2, data 0x40.
   - Read 0x1F then 0x00 → hit, data 0x00.
